// File: rtl/audio_player_pkg.sv
// -----------------------------------------------------------------------------
// audio_player_pkg
// Shared types and constants for the audio stream player:
//   state_e     - player FSM states (encoding is exported on state_dbg)
//   SAMPLE_W    - width of one PCM sample
//   BYTEEN_ALL  - byte enable used for every flash read (full 32-bit word)
// -----------------------------------------------------------------------------
package audio_player_pkg;

  localparam int         SAMPLE_W   = 16;
  localparam logic [3:0] BYTEEN_ALL = 4'b1111;

  typedef enum logic [2:0] {
    IDLE = 3'd0,  // waiting for an accepted sample tick
    REQ  = 3'd1,  // read request presented to the flash controller
    WAIT = 3'd2,  // request accepted, waiting for read data
    EMIT = 3'd3   // audio frame presented for one cycle
  } state_e;

endpackage

// File: rtl/audio_stream_player_if.sv
// -----------------------------------------------------------------------------
// audio_stream_player_if
// Pipelined flash read bus between the player (master) and the flash
// controller (slave).
//   address       - word address                        (master -> slave)
//   read          - read request                        (master -> slave)
//   byteenable    - byte lanes, always all four         (master -> slave)
//   waitrequest   - slave cannot accept the request     (slave -> master)
//   readdata      - returned 32-bit word                (slave -> master)
//   readdatavalid - readdata is valid this cycle        (slave -> master)
// -----------------------------------------------------------------------------
interface audio_stream_player_if
  import audio_player_pkg::*;
#(
  parameter int ADDR_W = 23
);

  logic [ADDR_W-1:0]             address;
  logic                          read;
  logic [$bits(BYTEEN_ALL)-1:0]  byteenable;
  logic                          waitrequest;
  logic [31:0]                   readdata;
  logic                          readdatavalid;

  modport master (
    output address, read, byteenable,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, read, byteenable,
    output waitrequest, readdata, readdatavalid
  );

endinterface

// File: rtl/window_addr_counter.sv
// -----------------------------------------------------------------------------
// window_addr_counter
// Up/down word-address counter confined to the window [LO, HI].
//   clk, rst  - clock, synchronous active-high reset (address -> LO)
//   load      - load load_val (takes priority over advance)
//   load_val  - value loaded on load
//   advance   - step one word in the direction given by up
//   up        - 1 = increment, 0 = decrement
//   loop_en   - at the window edge: 1 = wrap to the other edge, 0 = hold
//   addr      - next word address to fetch
//   at_edge   - addr sits on the edge an advance in direction up would cross
// -----------------------------------------------------------------------------
module window_addr_counter #(
  parameter int                ADDR_W = 23,
  parameter logic [ADDR_W-1:0] LO     = '0,
  parameter logic [ADDR_W-1:0] HI     = '1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_val,
  input  logic              advance,
  input  logic              up,
  input  logic              loop_en,
  output logic [ADDR_W-1:0] addr,
  output logic              at_edge
);

  logic [ADDR_W-1:0] step_addr;

  // NOTE: every variable gets a default before any branch, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    step_addr = addr;
    at_edge   = up ? (addr == HI) : (addr == LO);
    if (!at_edge) begin
      step_addr = up ? addr + ADDR_W'(1) : addr - ADDR_W'(1);
    end else if (loop_en) begin
      step_addr = up ? LO : HI;
    end
  end

  // NOTE: registers use non-blocking assignments so every flop samples the
  // values present before the clock edge, independent of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr <= LO;
    end else if (load) begin
      addr <= load_val;
    end else if (advance) begin
      addr <= step_addr;
    end
  end

endmodule

// File: rtl/audio_stream_player.sv
// -----------------------------------------------------------------------------
// audio_stream_player
// Fetches packed PCM words from flash and emits one audio frame per accepted
// sample tick. Mono packs two samples per word (the second half is buffered
// so every other tick needs no read); stereo carries L in [15:0] and R in
// [31:16]. Playback runs forward or reverse inside [START_ADDR, END_ADDR],
// looping or stopping with done at the window edge.
//   clk, rst      - clock, synchronous active-high reset
//   play_forward  - 1 = ascending addresses, 0 = descending
//   pause         - sample ticks are ignored while high
//   restart       - pulse: return to the window start for current direction
//   loop_en       - 1 = wrap at the window edge, 0 = stop and raise done
//   sample_tick   - one-cycle pulse at the sample rate
//   flsh          - flash read bus (master side)
//   audio_out     - current frame, SAMPLE_W bits per channel
//   audio_valid   - one-cycle pulse when audio_out updates
//   done          - one-shot playback reached the window edge
//   tick_drop     - one-cycle pulse: a tick arrived while busy
//   state_dbg     - current FSM state encoding
// -----------------------------------------------------------------------------
module audio_stream_player
  import audio_player_pkg::*;
#(
  parameter int                ADDR_W     = 23,
  parameter int                NUM_CH     = 1,
  parameter logic [ADDR_W-1:0] START_ADDR = '0,
  parameter logic [ADDR_W-1:0] END_ADDR   = ADDR_W'(23'h7FFFF)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       play_forward,
  input  logic                       pause,
  input  logic                       restart,
  input  logic                       loop_en,
  input  logic                       sample_tick,
  audio_stream_player_if.master      flsh,
  output logic [SAMPLE_W*NUM_CH-1:0] audio_out,
  output logic                       audio_valid,
  output logic                       done,
  output logic                       tick_drop,
  output logic [2:0]                 state_dbg
);

  localparam bit MONO    = (NUM_CH == 1);
  localparam int AUDIO_W = SAMPLE_W * NUM_CH;

  if (NUM_CH != 1 && NUM_CH != 2) begin : g_bad_num_ch
    $error("audio_stream_player: NUM_CH must be 1 (mono) or 2 (stereo)");
  end
  if (END_ADDR < START_ADDR) begin : g_bad_window
    $error("audio_stream_player: END_ADDR must be >= START_ADDR");
  end

  state_e              state_q, state_d;
  logic [SAMPLE_W-1:0] half_buf_q;
  logic                half_valid_q;
  logic                restart_pend_q;
  logic                emit_adv_q;    // current EMIT finishes its word
  logic                fetch_fwd_q;   // direction the current word was fetched in

  logic                tick_live;     // a tick that is not paused or done
  logic                tick_accept;
  logic                restart_now;   // restart applied at the next edge
  logic                discard;       // in-flight read data must be dropped
  logic                advance;
  logic                at_edge;
  logic [ADDR_W-1:0]   fetch_addr;
  logic [SAMPLE_W-1:0] rd_lo, rd_hi;

  assign rd_lo = flsh.readdata[SAMPLE_W-1:0];
  assign rd_hi = flsh.readdata[2*SAMPLE_W-1:SAMPLE_W];

  // Restart only takes effect in IDLE; elsewhere it is parked as pending so
  // the in-flight read can finish cleanly. It beats a simultaneous tick.
  assign restart_now = (restart || restart_pend_q) && (state_q == IDLE);
  assign tick_live   = sample_tick && !pause && !done;
  assign tick_accept = tick_live && (state_q == IDLE) && !restart_now;
  assign discard     = restart || restart_pend_q;
  assign advance     = (state_q == EMIT) && emit_adv_q;

  window_addr_counter #(
    .ADDR_W (ADDR_W),
    .LO     (START_ADDR),
    .HI     (END_ADDR)
  ) u_addr (
    .clk      (clk),
    .rst      (rst),
    .load     (restart_now),
    .load_val (play_forward ? START_ADDR : END_ADDR),
    .advance  (advance),
    .up       (fetch_fwd_q),
    .loop_en  (loop_en),
    .addr     (fetch_addr),
    .at_edge  (at_edge)
  );

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    flsh.read = 1'b0;
    case (state_q)
      IDLE: begin
        if (tick_accept) begin
          state_d = (MONO && half_valid_q) ? EMIT : REQ;
        end
      end
      REQ: begin
        flsh.read = 1'b1;
        if (!flsh.waitrequest) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (flsh.readdatavalid) begin
          state_d = discard ? IDLE : EMIT;
        end
      end
      EMIT:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign flsh.address    = fetch_addr;
  assign flsh.byteenable = BYTEEN_ALL;
  assign state_dbg       = state_q;

  // ---------------------------------------------------------------------------
  // Datapath. audio_out/audio_valid are loaded on the edge that enters EMIT,
  // so they are visible during the EMIT cycle itself.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      audio_out      <= '0;
      audio_valid    <= 1'b0;
      done           <= 1'b0;
      tick_drop      <= 1'b0;
      // NOTE: the half buffer is an ordinary register, so it is cleared in
      // reset along with its valid flag; a stale half can never play.
      half_buf_q     <= '0;
      half_valid_q   <= 1'b0;
      restart_pend_q <= 1'b0;
      emit_adv_q     <= 1'b0;
      fetch_fwd_q    <= 1'b1;
    end else begin
      audio_valid <= 1'b0;
      tick_drop   <= tick_live && ((state_q != IDLE) || restart_now);

      if (restart_now) begin
        restart_pend_q <= 1'b0;
        half_valid_q   <= 1'b0;
        done           <= 1'b0;
      end else if (restart && (state_q != IDLE)) begin
        restart_pend_q <= 1'b1;
      end

      // Mono second half: no read, and the word is now fully consumed.
      if (MONO && tick_accept && half_valid_q) begin
        audio_out    <= AUDIO_W'(half_buf_q);
        audio_valid  <= 1'b1;
        half_valid_q <= 1'b0;
        emit_adv_q   <= 1'b1;
      end

      if ((state_q == WAIT) && flsh.readdatavalid && !discard) begin
        audio_valid <= 1'b1;
        fetch_fwd_q <= play_forward;
        if (MONO) begin
          // Forward plays the low half first; reverse plays the high half.
          audio_out    <= AUDIO_W'(play_forward ? rd_lo : rd_hi);
          half_buf_q   <= play_forward ? rd_hi : rd_lo;
          half_valid_q <= 1'b1;
          emit_adv_q   <= 1'b0;
        end else begin
          audio_out    <= AUDIO_W'(flsh.readdata);
          emit_adv_q   <= 1'b1;
        end
      end

      // The edge frame has just been emitted; stop here in one-shot mode.
      if (advance && at_edge && !loop_en) begin
        done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_audio_stream_player.sv
// -----------------------------------------------------------------------------
// tb_audio_stream_player
// Directed bench with two players on a 4-word window [0,3]: a stereo instance
// and a mono instance, each with its own behavioural flash model (configurable
// waitrequest hold and read latency). Inputs are driven and outputs sampled on
// the falling clock edge.
// -----------------------------------------------------------------------------
module tb_audio_stream_player;
  import audio_player_pkg::*;

  localparam int AW = 23;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, play_forward, pause, restart, loop_en;
  logic st_tick, mo_tick;
  logic [31:0] st_audio;
  logic [15:0] mo_audio;
  logic st_valid, mo_valid, st_done, mo_done, st_drop, mo_drop;
  logic [2:0] st_state, mo_state;

  audio_stream_player_if #(.ADDR_W(AW)) st_bus ();
  audio_stream_player_if #(.ADDR_W(AW)) mo_bus ();

  audio_stream_player #(
    .ADDR_W(AW), .NUM_CH(2), .START_ADDR(23'd0), .END_ADDR(23'd3)
  ) u_st (
    .clk(clk), .rst(rst), .play_forward(play_forward), .pause(pause),
    .restart(restart), .loop_en(loop_en), .sample_tick(st_tick),
    .flsh(st_bus), .audio_out(st_audio), .audio_valid(st_valid),
    .done(st_done), .tick_drop(st_drop), .state_dbg(st_state)
  );

  audio_stream_player #(
    .ADDR_W(AW), .NUM_CH(1), .START_ADDR(23'd0), .END_ADDR(23'd3)
  ) u_mo (
    .clk(clk), .rst(rst), .play_forward(play_forward), .pause(pause),
    .restart(restart), .loop_en(loop_en), .sample_tick(mo_tick),
    .flsh(mo_bus), .audio_out(mo_audio), .audio_valid(mo_valid),
    .done(mo_done), .tick_drop(mo_drop), .state_dbg(mo_state)
  );

  // ---------------------------------------------------------------------------
  // Flash models: waitrequest held for *_hold cycles of each request; data
  // returns the cycle after acceptance when *_lat = 0, later otherwise.
  // ---------------------------------------------------------------------------
  logic [31:0] st_mem [4];
  logic [31:0] mo_mem [4];
  int st_hold = 0, st_lat = 0, st_wcnt = 0, st_cnt = 0, st_reads = 0;
  int mo_hold = 0, mo_lat = 0, mo_wcnt = 0, mo_cnt = 0, mo_reads = 0;
  logic st_pend = 1'b0, mo_pend = 1'b0;
  logic [31:0] st_pdata, mo_pdata;
  logic [AW-1:0] st_last = '0, mo_last = '0;
  logic st_acc, mo_acc;

  assign st_bus.waitrequest = st_bus.read && (st_wcnt < st_hold);
  assign mo_bus.waitrequest = mo_bus.read && (mo_wcnt < mo_hold);
  assign st_acc = st_bus.read && !st_bus.waitrequest;
  assign mo_acc = mo_bus.read && !mo_bus.waitrequest;

  initial begin
    st_bus.readdatavalid = 1'b0; st_bus.readdata = '0;
    mo_bus.readdatavalid = 1'b0; mo_bus.readdata = '0;
  end

  always @(posedge clk) begin
    st_bus.readdatavalid <= 1'b0;
    if (st_bus.read && st_bus.waitrequest) st_wcnt <= st_wcnt + 1;
    if (st_acc) begin
      st_wcnt  <= 0;
      st_reads <= st_reads + 1;
      st_last  <= st_bus.address;
      if (st_lat == 0) begin
        st_bus.readdatavalid <= 1'b1;
        st_bus.readdata      <= st_mem[st_bus.address[1:0]];
      end else begin
        st_pend  <= 1'b1;
        st_cnt   <= st_lat;
        st_pdata <= st_mem[st_bus.address[1:0]];
      end
    end else if (st_pend) begin
      if (st_cnt == 1) begin
        st_bus.readdatavalid <= 1'b1;
        st_bus.readdata      <= st_pdata;
        st_pend              <= 1'b0;
      end else begin
        st_cnt <= st_cnt - 1;
      end
    end
  end

  always @(posedge clk) begin
    mo_bus.readdatavalid <= 1'b0;
    if (mo_bus.read && mo_bus.waitrequest) mo_wcnt <= mo_wcnt + 1;
    if (mo_acc) begin
      mo_wcnt  <= 0;
      mo_reads <= mo_reads + 1;
      mo_last  <= mo_bus.address;
      if (mo_lat == 0) begin
        mo_bus.readdatavalid <= 1'b1;
        mo_bus.readdata      <= mo_mem[mo_bus.address[1:0]];
      end else begin
        mo_pend  <= 1'b1;
        mo_cnt   <= mo_lat;
        mo_pdata <= mo_mem[mo_bus.address[1:0]];
      end
    end else if (mo_pend) begin
      if (mo_cnt == 1) begin
        mo_bus.readdatavalid <= 1'b1;
        mo_bus.readdata      <= mo_pdata;
        mo_pend              <= 1'b0;
      end else begin
        mo_cnt <= mo_cnt - 1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Checking helpers
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One-cycle tick on the selected instance; returns on the next falling edge.
  task automatic pulse_tick(input bit mono);
    if (mono) mo_tick = 1'b1; else st_tick = 1'b1;
    @(negedge clk);
    mo_tick = 1'b0;
    st_tick = 1'b0;
  endtask

  // Cycles from the tick cycle to audio_valid (1 = the cycle after the tick);
  // 99 if it never arrives within the budget.
  task automatic wait_av(input bit mono, output int cyc);
    cyc = 1;
    while (!(mono ? mo_valid : st_valid) && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    if (!(mono ? mo_valid : st_valid)) cyc = 99;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int cyc, nv, nd, nr;
    rst = 1'b1; play_forward = 1'b1; pause = 1'b0; restart = 1'b0;
    loop_en = 1'b0; st_tick = 1'b0; mo_tick = 1'b0;
    st_mem = '{32'hBBBB_AAAA, 32'hDDDD_CCCC, 32'h1234_5678, 32'hCAFE_F00D};
    mo_mem = '{32'h2222_1111, 32'h2222_1111, 32'h6666_5555, 32'h8888_7777};
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_addr",   st_bus.address, 0);
    check("rst_read",   st_bus.read, 0);
    check("rst_be",     st_bus.byteenable, 4'hF);
    check("rst_audio",  st_audio, 0);
    check("rst_valid",  st_valid, 0);
    check("rst_done",   st_done, 0);
    check("rst_drop",   st_drop, 0);
    check("rst_state",  st_state, 0);
    check("rst_mo_aud", mo_audio, 0);
    rst = 1'b0;
    @(negedge clk);

    // Stereo forward, waitrequest held 2 cycles
    st_hold = 2;
    pulse_tick(1'b0);
    check("t1_read_c1", st_bus.read, 1);
    check("t1_addr_c1", st_bus.address, 0);
    @(negedge clk); check("t1_read_c2", st_bus.read, 1);
    @(negedge clk); check("t1_read_c3", st_bus.read, 1);
    check("t1_addr_c3", st_bus.address, 0);
    @(negedge clk); check("t1_read_off", st_bus.read, 0);
    check("t1_valid_early", st_valid, 0);
    @(negedge clk); check("t1_valid", st_valid, 1);
    check("t1_audio", st_audio, 32'hBBBB_AAAA);
    @(negedge clk); check("t1_valid_pulse", st_valid, 0);
    check("t1_addr_next", st_bus.address, 1);
    check("t1_reads", st_reads, 1);
    st_hold = 0;

    // Mono forward: one read, two samples
    pulse_tick(1'b1); wait_av(1'b1, cyc);
    check("t2_lat_fetch", cyc, 3);
    check("t2_first", mo_audio, 16'h1111);
    @(negedge clk); check("t2_addr_hold", mo_bus.address, 0);
    pulse_tick(1'b1); wait_av(1'b1, cyc);
    check("t2_lat_buf", cyc, 1);
    check("t2_second", mo_audio, 16'h2222);
    check("t2_reads", mo_reads, 1);
    @(negedge clk); check("t2_addr_adv", mo_bus.address, 1);

    // Mono reverse on the same word
    play_forward = 1'b0;
    pulse_tick(1'b1); wait_av(1'b1, cyc);
    check("t3_first", mo_audio, 16'h2222);
    @(negedge clk);
    pulse_tick(1'b1); wait_av(1'b1, cyc);
    check("t3_second", mo_audio, 16'h1111);
    check("t3_reads", mo_reads, 2);
    @(negedge clk); check("t3_addr_dec", mo_bus.address, 0);

    // Mono reverse with loop at START_ADDR wraps to END_ADDR
    loop_en = 1'b1;
    pulse_tick(1'b1); wait_av(1'b1, cyc);
    check("t3b_fetch_addr", mo_last, 0);
    check("t3b_first", mo_audio, 16'h2222);
    @(negedge clk);
    pulse_tick(1'b1); wait_av(1'b1, cyc);
    check("t3b_second", mo_audio, 16'h1111);
    @(negedge clk); check("t3b_wrap_addr", mo_bus.address, 3);
    check("t3b_done", mo_done, 0);
    pulse_tick(1'b1); wait_av(1'b1, cyc);
    check("t3b_wrap_fetch", mo_last, 3);
    check("t3b_wrap_audio", mo_audio, 16'h8888);
    @(negedge clk);
    pulse_tick(1'b1); wait_av(1'b1, cyc);
    check("t3b_wrap_second", mo_audio, 16'h7777);
    @(negedge clk); check("t3b_addr2", mo_bus.address, 2);
    loop_en = 1'b0;
    play_forward = 1'b1;

    // Stereo one-shot to END_ADDR
    pulse_tick(1'b0); wait_av(1'b0, cyc);
    check("t4_a1", st_audio, 32'hDDDD_CCCC);
    @(negedge clk);
    pulse_tick(1'b0); wait_av(1'b0, cyc);
    check("t4_a2", st_audio, 32'h1234_5678);
    @(negedge clk); check("t4_done_before", st_done, 0);
    pulse_tick(1'b0); wait_av(1'b0, cyc);
    check("t4_a3_edge", st_audio, 32'hCAFE_F00D);
    @(negedge clk); check("t4_done", st_done, 1);
    check("t4_addr_hold", st_bus.address, 3);
    pulse_tick(1'b0);
    nv = 0; nd = 0; nr = 0;
    for (int i = 0; i < 10; i++) begin
      if (st_valid) nv++;
      if (st_drop) nd++;
      if (st_bus.read) nr++;
      @(negedge clk);
    end
    check("t4_ign_valid", nv, 0);
    check("t4_ign_drop", nd, 0);
    check("t4_ign_read", nr, 0);
    check("t4_done_stays", st_done, 1);
    restart = 1'b1;
    @(negedge clk); restart = 1'b0;
    check("t4_rs_addr", st_bus.address, 0);
    check("t4_rs_done", st_done, 0);
    check("t4_rs_mo_addr", mo_bus.address, 0);

    // Stereo forward loop at END_ADDR
    loop_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      pulse_tick(1'b0); wait_av(1'b0, cyc);
      @(negedge clk);
    end
    check("t5_at_end", st_bus.address, 3);
    pulse_tick(1'b0); wait_av(1'b0, cyc);
    check("t5_edge_audio", st_audio, 32'hCAFE_F00D);
    @(negedge clk); check("t5_wrap_addr", st_bus.address, 0);
    check("t5_no_done", st_done, 0);
    pulse_tick(1'b0); wait_av(1'b0, cyc);
    check("t5_wrap_lat", cyc, 3);
    check("t5_wrap_fetch", st_last, 0);
    check("t5_wrap_audio", st_audio, 32'hBBBB_AAAA);
    @(negedge clk);
    loop_en = 1'b0;

    // Restart during WAIT discards the returning data; tick in WAIT drops
    st_lat = 4;
    check("t6_addr_pre", st_bus.address, 1);
    pulse_tick(1'b0);
    @(negedge clk); check("t6_state_wait", st_state, 3'd2);
    st_tick = 1'b1;
    @(negedge clk); st_tick = 1'b0;
    check("t6_drop", st_drop, 1);
    restart = 1'b1;
    @(negedge clk); restart = 1'b0;
    check("t6_drop_pulse", st_drop, 0);
    nv = 0;
    for (int i = 0; i < 12; i++) begin
      if (st_valid) nv++;
      @(negedge clk);
    end
    check("t6_no_valid", nv, 0);
    check("t6_addr_start", st_bus.address, 0);
    check("t6_state_idle", st_state, 3'd0);
    st_lat = 0;

    // Simultaneous tick and restart in IDLE: restart wins, tick dropped
    play_forward = 1'b0;
    st_tick = 1'b1; restart = 1'b1;
    @(negedge clk); st_tick = 1'b0; restart = 1'b0;
    check("t7_drop", st_drop, 1);
    check("t7_addr_end", st_bus.address, 3);
    check("t7_no_read", st_bus.read, 0);
    @(negedge clk); check("t7_no_read2", st_bus.read, 0);
    check("t7_no_valid", st_valid, 0);
    play_forward = 1'b1;

    // Paused ticks are silently ignored
    pause = 1'b1;
    pulse_tick(1'b0);
    nd = 0; nr = 0;
    for (int i = 0; i < 5; i++) begin
      if (st_drop) nd++;
      if (st_bus.read) nr++;
      @(negedge clk);
    end
    check("t8_pause_drop", nd, 0);
    check("t8_pause_read", nr, 0);
    pause = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
